// File: rtl/aes128_pkg.sv
// Shared AES-128 constants, helpers and types.
// Byte 0 of every block/key lives in bits [127:120].
package aes128_pkg;

  typedef logic [127:0] block_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
    8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
    8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
    8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
    8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
    8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
    8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
    8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
    8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
    8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
    8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Indexed directly by round number 1..10; other slots are zero.
  localparam logic [7:0] RCON [16] = '{
    8'h00, 8'h01, 8'h02, 8'h04,
    8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00,
    8'h00, 8'h00, 8'h00, 8'h00
  };

  function automatic logic [7:0] xtime(
    input logic [7:0] b
  );
    return {b[6:0], 1'b0} ^
           (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] sbox(
    input logic [7:0] b
  );
    return SBOX[b];
  endfunction

endpackage

// File: rtl/aes128_round_comb.sv
// One combinational AES-128 round with on-the-fly
// key expansion: derives K_r, then applies round r.
module aes128_round_comb
  import aes128_pkg::*;
(
  input  block_t     state,
  input  block_t     rkey,
  input  logic [3:0] rnd,
  input  logic       is_last,
  output block_t     next_state,
  output block_t     next_rkey
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] t;
  logic [31:0] k0, k1, k2, k3;
  block_t      sr;
  block_t      mc;

  assign {w0, w1, w2, w3} = rkey;

  assign t = {
    sbox(w3[23:16]) ^ RCON[rnd],
    sbox(w3[15:8]),
    sbox(w3[7:0]),
    sbox(w3[31:24])
  };

  assign k0 = w0 ^ t;
  assign k1 = w1 ^ k0;
  assign k2 = w2 ^ k1;
  assign k3 = w3 ^ k2;

  assign next_rkey = {k0, k1, k2, k3};

  // SubBytes fused with ShiftRows: row r rotates left by r.
  for (genvar i = 0; i < 16; i++) begin : g_sr
    localparam int R = i % 4;
    localparam int C = i / 4;
    localparam int S = R + 4 * ((C + R) % 4);
    assign sr[127-8*i -: 8] =
      sbox(state[127-8*S -: 8]);
  end

  for (genvar c = 0; c < 4; c++) begin : g_mc
    logic [7:0] a0, a1, a2, a3;
    assign a0 = sr[127-32*c -: 8];
    assign a1 = sr[119-32*c -: 8];
    assign a2 = sr[111-32*c -: 8];
    assign a3 = sr[103-32*c -: 8];
    assign mc[127-32*c -: 32] = {
      xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
      a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
      a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
      xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)
    };
  end

  assign next_state =
    (is_last ? sr : mc) ^ next_rkey;

endmodule

// File: rtl/aes128_iter_engine.sv
// Iterative AES-128 encryptor, RPC rounds per clock,
// valid/ready in and out, tag carried alongside.
module aes128_iter_engine
  import aes128_pkg::*;
#(
  parameter int RPC   = 1,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_data,
  input  logic [127:0]     in_key,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_data,
  output logic [TAG_W-1:0] out_tag
);

  if (!(RPC == 1 || RPC == 2 ||
        RPC == 5 || RPC == 10)) begin : g_bad_rpc
    $fatal(1, "RPC must be 1, 2, 5 or 10");
  end

  if (TAG_W < 1) begin : g_bad_tag
    $fatal(1, "TAG_W must be at least 1");
  end

  localparam logic [3:0] STEP = 4'(RPC);

  state_t           fsm;
  block_t           state_reg;
  block_t           rkey_reg;
  logic [TAG_W-1:0] tag_reg;
  logic [3:0]       rnd;
  logic [3:0]       rnd_nxt;
  logic             accept;

  block_t st_c [RPC+1];
  block_t rk_c [RPC+1];

  assign in_ready =
    (fsm == IDLE) ||
    (fsm == DONE && out_ready);
  assign accept  = in_valid && in_ready;
  assign rnd_nxt = rnd + STEP;

  assign st_c[0] = state_reg;
  assign rk_c[0] = rkey_reg;

  // Chain of RPC rounds; stage g computes round rnd+g+1.
  for (genvar g = 0; g < RPC; g++) begin : g_rnd
    logic [3:0] ridx;
    assign ridx = rnd + 4'(g + 1);
    aes128_round_comb u_round (
      .state      (st_c[g]),
      .rkey       (rk_c[g]),
      .rnd        (ridx),
      .is_last    (ridx == 4'd10),
      .next_state (st_c[g+1]),
      .next_rkey  (rk_c[g+1])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm       <= IDLE;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tag   <= '0;
      rnd       <= '0;
      state_reg <= '0;
      rkey_reg  <= '0;
      tag_reg   <= '0;
    end else begin
      unique case (fsm)
        IDLE: begin
          if (accept) begin
            fsm <= BUSY;
          end
        end
        BUSY: begin
          state_reg <= st_c[RPC];
          rkey_reg  <= rk_c[RPC];
          rnd       <= rnd_nxt;
          if (rnd_nxt == 4'd10) begin
            fsm       <= DONE;
            out_valid <= 1'b1;
            out_data  <= st_c[RPC];
            out_tag   <= tag_reg;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            fsm       <= accept ? BUSY : IDLE;
          end
        end
        default: begin
          fsm       <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
      // Loading overrides BUSY updates; only IDLE/DONE accept.
      if (accept) begin
        state_reg <= in_data ^ in_key;
        rkey_reg  <= in_key;
        tag_reg   <= in_tag;
        rnd       <= '0;
      end
    end
  end

endmodule

// File: tb/tb_aes128_iter_engine.sv
// Bench for aes128_iter_engine: FIPS-197 vectors, latency,
// backpressure, back-to-back, busy-ignore and mid-block reset.
module tb_aes128_iter_engine;

  localparam int N = 10;
  localparam logic [127:0] C1K  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1P  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] BK   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] BP   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] BC   = 128'h3925841d02dc09fbdc118597196a0b32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] din = '0;
  logic [127:0] kin = '0;
  logic [7:0]   tin = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [127:0] out_data;
  logic [7:0]   out_tag;

  logic [2:0]   xv = '0;
  logic [2:0]   xir;
  logic [2:0]   xov;
  logic [127:0] xod [3];
  logic [7:0]   xot [3];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes128_iter_engine #(.RPC(1), .TAG_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (din),
    .in_key    (kin),
    .in_tag    (tin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag)
  );

  for (genvar k = 0; k < 3; k++) begin : g_x
    aes128_iter_engine #(
      .RPC   (k == 0 ? 2 : (k == 1 ? 5 : 10)),
      .TAG_W (8)
    ) u_x (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (xv[k]),
      .in_ready  (xir[k]),
      .in_data   (din),
      .in_key    (kin),
      .in_tag    (tin),
      .out_valid (xov[k]),
      .out_ready (1'b1),
      .out_data  (xod[k]),
      .out_tag   (xot[k])
    );
  end

  function automatic void chk(input string nm,
                              input logic [127:0] act,
                              input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h want %h",
               nm, cyc, act, exp);
    end
  endfunction

  // Reference AES built from GF(2^8) arithmetic.
  logic [7:0] msbox [256];

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                     input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  initial begin
    logic [7:0] inv;
    logic [7:0] x;
    for (int b = 0; b < 256; b++) begin
      inv = 8'h01;
      for (int e = 0; e < 254; e++) inv = gmul(inv, 8'(b));
      x = inv;
      msbox[b] = x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^
                 {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]} ^ 8'h63;
    end
  end

  function automatic logic [127:0] aes_enc(input logic [127:0] pt,
                                           input logic [127:0] key);
    logic [31:0]  w [44];
    logic [31:0]  tmp;
    logic [7:0]   rc;
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] res;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {msbox[tmp[31:24]], msbox[tmp[23:16]],
               msbox[tmp[15:8]], msbox[tmp[7:0]]};
        tmp[31:24] ^= rc;
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++)
      s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++)
        t[i] = msbox[s[(i%4) + 4*(((i/4) + (i%4)) % 4)]];
      for (int c = 0; c < 4; c++) begin
        if (r < 10) begin
          s[4*c]   = gmul(t[4*c], 2) ^ gmul(t[4*c+1], 3) ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 2) ^ gmul(t[4*c+2], 3) ^ t[4*c+3];
          s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 2) ^ gmul(t[4*c+3], 3);
          s[4*c+3] = gmul(t[4*c], 3) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 2);
        end else begin
          for (int j = 0; j < 4; j++) s[4*c+j] = t[4*c+j];
        end
      end
      for (int i = 0; i < 16; i++)
        s[i] ^= w[4*r + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // Transaction-level model: a block spends N cycles in flight,
  // then is offered until taken; nothing enters while occupied.
  logic         m_init = 1'b0;
  logic         m_busy = 1'b0;
  logic         m_valid = 1'b0;
  logic         m_rdy;
  int           m_cnt = 0;
  logic [127:0] m_data, m_pend;
  logic [7:0]   m_tag, m_ptag;

  always @(negedge clk) begin
    if (rst) begin
      m_init  = 1'b1;
      m_busy  = 1'b0;
      m_valid = 1'b0;
      m_cnt   = 0;
    end else if (m_init) begin
      m_rdy = !m_busy && (!m_valid || out_ready);
      chk("cmp_in_ready", in_ready, m_rdy);
      chk("cmp_out_valid", out_valid, m_valid);
      if (m_valid) begin
        chk("cmp_out_data", out_data, m_data);
        chk("cmp_out_tag", out_tag, m_tag);
      end
      if (m_busy) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_busy  = 1'b0;
          m_valid = 1'b1;
          m_data  = m_pend;
          m_tag   = m_ptag;
        end
      end else begin
        if (m_valid && out_ready) m_valid = 1'b0;
        if (in_valid && m_rdy) begin
          m_busy = 1'b1;
          m_cnt  = N;
          m_pend = aes_enc(din, kin);
          m_ptag = tin;
        end
      end
    end
  end

  logic         mon_en = 1'b0;
  logic [7:0]   tq [$];
  logic [127:0] dq [$];

  always @(negedge clk) begin
    if (mon_en && !rst && out_valid && out_ready) begin
      tq.push_back(out_tag);
      dq.push_back(out_data);
    end
  end

  task automatic drive(input logic [127:0] d,
                       input logic [127:0] k,
                       input logic [7:0] t);
    in_valid = 1'b1;
    din = d;
    kin = k;
    tin = t;
  endtask

  task automatic do_accept(output int t0);
    logic r;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      r = in_ready;
      @(posedge clk);
      #1;
      if (r) begin
        t0 = cyc;
        return;
      end
    end
    chk("accept_timeout", 1'b0, 1'b1);
    t0 = cyc;
  endtask

  task automatic wait_valid(input int t0, output int lat,
                            output logic [127:0] d,
                            output logic [7:0] t);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = cyc - t0;
        d = out_data;
        t = out_tag;
        return;
      end
    end
    lat = -1;
    d = 'x;
    t = 'x;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int           t0, t1, lat, bad;
    int           xl [3];
    logic [127:0] d;
    logic [7:0]   t;
    logic [2:0]   seen;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 128'h0);
    chk("rst_out_tag", out_tag, 8'h00);
    chk("rst_x_in_ready", xir, 3'b111);

    chk("model_c1", aes_enc(C1P, C1K), C1C);
    chk("model_b", aes_enc(BP, BK), BC);

    // FIPS-197 C.1 and App. B on the RPC=1 engine
    @(posedge clk); #1;
    drive(C1P, C1K, 8'hA5);
    do_accept(t0);
    in_valid = 1'b0;
    wait_valid(t0, lat, d, t);
    chk("c1_latency", lat, 10);
    chk("c1_data", d, C1C);
    chk("c1_tag", t, 8'hA5);

    @(posedge clk); #1;
    drive(BP, BK, 8'h5A);
    do_accept(t0);
    in_valid = 1'b0;
    wait_valid(t0, lat, d, t);
    chk("b_latency", lat, 10);
    chk("b_data", d, BC);
    chk("b_tag", t, 8'h5A);

    // C.1 on the RPC=2,5,10 engines
    @(posedge clk); #1;
    din = C1P; kin = C1K; tin = 8'h21;
    xv = 3'b111;
    @(posedge clk); #1;
    t0 = cyc;
    xv = '0;
    seen = '0;
    for (int k = 0; k < 3; k++) xl[k] = -1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (xov[k] && !seen[k]) begin
          seen[k] = 1'b1;
          xl[k] = cyc - t0;
          chk("x_data", xod[k], C1C);
          chk("x_tag", xot[k], 8'h21);
        end
      end
    end
    chk("x_seen", seen, 3'b111);
    chk("x_lat_rpc2", xl[0], 5);
    chk("x_lat_rpc5", xl[1], 2);
    chk("x_lat_rpc10", xl[2], 1);

    // Backpressure for 20 cycles
    @(posedge clk); #1;
    out_ready = 1'b0;
    drive(BP, BK, 8'h33);
    do_accept(t0);
    in_valid = 1'b0;
    wait_valid(t0, lat, d, t);
    chk("bp_latency", lat, 10);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_valid", out_valid, 1'b1);
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_data", out_data, BC);
      chk("bp_tag", out_tag, 8'h33);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", in_ready, 1'b1);
    @(negedge clk);
    chk("bp_idle_valid", out_valid, 1'b0);
    chk("bp_idle_ready", in_ready, 1'b1);

    // Back-to-back: second block taken in the DONE cycle
    @(posedge clk); #1;
    tq.delete();
    dq.delete();
    mon_en = 1'b1;
    drive(C1P, C1K, 8'h01);
    do_accept(t0);
    drive(BP, BK, 8'h02);
    do_accept(t1);
    in_valid = 1'b0;
    chk("b2b_gap", t1 - t0, N + 1);
    repeat (14) @(posedge clk);
    #1 mon_en = 1'b0;
    chk("b2b_count", tq.size(), 2);
    if (tq.size() == 2) begin
      chk("b2b_tag0", tq[0], 8'h01);
      chk("b2b_tag1", tq[1], 8'h02);
      chk("b2b_data0", dq[0], C1C);
      chk("b2b_data1", dq[1], BC);
    end

    // in_valid toggled and data changed while busy
    @(posedge clk); #1;
    drive(BP, BK, 8'h44);
    do_accept(t0);
    for (int i = 0; i < 6; i++) begin
      in_valid = ~in_valid;
      din = {$urandom, $urandom, $urandom, $urandom};
      kin = {$urandom, $urandom, $urandom, $urandom};
      tin = 8'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    wait_valid(t0, lat, d, t);
    chk("busy_latency", lat, 10);
    chk("busy_data", d, BC);
    chk("busy_tag", t, 8'h44);

    // Reset mid-block, then a fresh block
    @(posedge clk); #1;
    drive(BP, BK, 8'h66);
    do_accept(t0);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (out_valid) bad++;
    end
    chk("rst_mid_no_output", bad, 0);
    chk("rst_mid_out_data", out_data, 128'h0);
    @(posedge clk); #1;
    drive(C1P, C1K, 8'h55);
    do_accept(t0);
    in_valid = 1'b0;
    wait_valid(t0, lat, d, t);
    chk("post_rst_latency", lat, 10);
    chk("post_rst_data", d, C1C);
    chk("post_rst_tag", t, 8'h55);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
